ksa_arb_seq: RTL and testbench

KSA_ARB_SEQ -- requirements
Module: ksa_arb_seq

---
 rtl/ksa_arb_seq.sv | 138 +++++++++++++
 tb/tb_ksa_arb_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ksa_arb_seq.sv
// Two-requester arbitrated add/sub unit. One W-bit Kogge-Stone adder is
// reused once per word, so an N-bit operation takes NWORDS cycles in RUN.
// Results are held in DONE until the consumer takes them.
module ksa_arb_seq #(
  parameter int WIDIDX = 3,
  parameter int NWORDS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req0_valid,
  output logic                                 req0_ready,
  input  logic [NWORDS*(2**WIDIDX)-1:0]        req0_a,
  input  logic [NWORDS*(2**WIDIDX)-1:0]        req0_b,
  input  logic                                 req0_sub,
  input  logic                                 req1_valid,
  output logic                                 req1_ready,
  input  logic [NWORDS*(2**WIDIDX)-1:0]        req1_a,
  input  logic [NWORDS*(2**WIDIDX)-1:0]        req1_b,
  input  logic                                 req1_sub,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [NWORDS*(2**WIDIDX)-1:0]        resp_sum,
  output logic                                 resp_cout,
  output logic                                 resp_id,
  output logic                                 busy
);
  localparam int W  = 2**WIDIDX;
  localparam int N  = NWORDS*W;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q, res_q;
  logic            sub_q, id_q, carry_q, ptr_q;
  logic [KW-1:0]   k_q;

  logic            any_v, gnt_id, accept, last_word;
  logic [W-1:0]    wa, wb, pw, wsum;
  logic            wcout;
  logic [WIDIDX:0][W-1:0] g_l, p_l;

  // Arbitration: a lone requester wins; a tie goes to the one not served last.
  always_comb begin
    any_v  = req0_valid | req1_valid;
    gnt_id = (req0_valid & req1_valid) ? ~ptr_q : req1_valid;
    accept = (state_q == IDLE) & any_v;
  end

  assign last_word = (k_q == KW'(NWORDS-1));

  // Word-serial Kogge-Stone prefix adder; carry-in folded into bit 0 generate.
  always_comb begin
    wa = a_q[k_q*W +: W];
    wb = sub_q ? ~b_q[k_q*W +: W] : b_q[k_q*W +: W];
    pw = wa ^ wb;
    g_l = '0;
    p_l = '0;
    g_l[0] = wa & wb;
    g_l[0][0] = (wa[0] & wb[0]) | (pw[0] & carry_q);
    p_l[0] = pw;
    for (int l = 0; l < WIDIDX; l++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << l)) begin
          g_l[l+1][i] = g_l[l][i] | (p_l[l][i] & g_l[l][i-(1<<l)]);
          p_l[l+1][i] = p_l[l][i] & p_l[l][i-(1<<l)];
        end else begin
          g_l[l+1][i] = g_l[l][i];
          p_l[l+1][i] = p_l[l][i];
        end
      end
    end
    wsum  = pw ^ {g_l[WIDIDX][W-2:0], carry_q};
    wcout = g_l[WIDIDX][W-1];
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = any_v & ~gnt_id;
        req1_ready = any_v &  gnt_id;
        if (accept) state_d = RUN;
      end
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture on accept, then one result word per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
      ptr_q   <= 1'b1;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q     <= gnt_id ? req1_a   : req0_a;
          b_q     <= gnt_id ? req1_b   : req0_b;
          sub_q   <= gnt_id ? req1_sub : req0_sub;
          carry_q <= gnt_id ? req1_sub : req0_sub;
          id_q    <= gnt_id;
          ptr_q   <= gnt_id;
          k_q     <= '0;
        end
        RUN: begin
          res_q[k_q*W +: W] <= wsum;
          carry_q           <= wcout;
          k_q               <= last_word ? '0 : k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state_q == DONE);
  assign resp_sum   = res_q;
  assign resp_cout  = carry_q & (state_q == DONE);
  assign resp_id    = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ksa_arb_seq.sv
// Scoreboard bench for ksa_arb_seq: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every response handshake.
module tb_ksa_arb_seq;
  localparam int WIDIDX = 3;
  localparam int NWORDS = 4;
  localparam int N = NWORDS * (2**WIDIDX);

  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_sub = 0, req1_sub = 0, resp_ready = 1;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, resp_valid, resp_cout, resp_id, busy;
  logic [N-1:0] resp_sum;

  ksa_arb_seq #(.WIDIDX(WIDIDX), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout),
    .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] sum; logic cout; logic id; } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0;
  logic pv = 0, pr = 0, pc = 0, pid = 0;
  logic [N-1:0] ps = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: handshake rules, latency, hold stability, scoreboard pop.
  always @(negedge clk) begin
    if (rst) begin
      pv = 0; pr = 0;
    end else begin
      if (req0_ready && req1_ready) chk("ready_both", 1, 0);
      if ((req0_ready || req1_ready) && busy) chk("ready_while_busy", 1, 0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc + 1;
      if (resp_valid) begin
        chk("busy_in_done", busy, 1);
        if (!pv) chk("latency", cyc - acc_cyc, NWORDS);
        if (pv && !pr) begin
          chk("hold_sum", resp_sum, ps);
          chk("hold_cout", resp_cout, pc);
          chk("hold_id", resp_id, pid);
        end
        if (resp_ready) begin
          if (sb.size() == 0) chk("unexpected_resp", 1, 0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("sum", resp_sum, e.sum);
            chk("cout", resp_cout, e.cout);
            chk("id", resp_id, e.id);
          end
        end
      end
      pv = resp_valid; pr = resp_ready; ps = resp_sum; pc = resp_cout; pid = resp_id;
    end
  end

  task automatic push(input logic [N-1:0] s, input logic c, input logic id);
    exp_t e;
    e.sum = s; e.cout = c; e.id = id;
    sb.push_back(e);
  endtask

  // Issue one op; operands are scrambled right after the accept edge.
  task automatic issue(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic sub, input logic [N-1:0] es, input logic ec);
    int n = 0;
    @(posedge clk); #1;
    if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1; end
    else    begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1; end
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", 1, 0);
    else push(es, ec, id);
    @(posedge clk); #1;
    if (id) begin req1_valid = 0; req1_a = $urandom; req1_b = $urandom; req1_sub = ~sub; end
    else    begin req0_valid = 0; req0_a = $urandom; req0_b = $urandom; req0_sub = ~sub; end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int n, acc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_sum", resp_sum, 0);
    chk("rst_cout", resp_cout, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 0;

    // Both requesters held valid from reset: grants alternate 0,1,0,1.
    @(posedge clk); #1;
    req0_a = 32'd1;  req0_b = 32'd2;  req0_sub = 0; req0_valid = 1;
    req1_a = 32'd10; req1_b = 32'd20; req1_sub = 0; req1_valid = 1;
    for (int i = 0; i < 2; i++) begin
      push(32'd3, 0, 0);
      push(32'd30, 0, 1);
    end
    acc = 0; n = 0;
    while (acc < 4 && n < 200) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        chk("busy_idle", busy, 0);
        acc++;
        @(posedge clk); #1;
        chk("busy_run", busy, 1);
        if (acc == 4) begin req0_valid = 0; req1_valid = 0; end
      end
      n++;
    end
    if (n >= 200) chk("alt_timeout", 1, 0);
    drain();

    issue(0, 32'h000000FF, 32'h00000001, 0, 32'h00000100, 0);
    drain();
    issue(1, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1);
    drain();
    issue(0, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 0);
    drain();
    issue(1, 32'd7, 32'd5, 1, 32'h00000002, 1);
    drain();

    // Backpressure in DONE with req1 pending.
    resp_ready = 0;
    issue(0, 32'h80000000, 32'h80000001, 0, 32'h00000001, 1);
    @(posedge clk); #1;
    req1_a = 32'h00000010; req1_b = 32'h00000020; req1_sub = 1; req1_valid = 1;
    push(32'hFFFFFFF0, 0, 1);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("done_timeout", 1, 0);
    repeat (10) @(negedge clk);
    chk("bp_valid", resp_valid, 1);
    chk("bp_no_ready1", req1_ready, 0);
    @(posedge clk); #1; resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_accept", req1_ready, 1);
    @(posedge clk); #1; req1_valid = 0;
    drain();

    // Reset during RUN word 2 discards the op.
    issue(1, 32'h0000FFFF, 32'h00000001, 0, 32'h00010000, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1; #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_sum", resp_sum, 0);
    chk("mid_rst_cout", resp_cout, 0);
    chk("mid_rst_id", resp_id, 0);
    chk("mid_rst_busy", busy, 0);
    sb.delete();
    @(negedge clk); rst = 0;

    // First tie after reset goes to req0.
    @(posedge clk); #1;
    req0_a = 32'h12345678; req0_b = 32'h11111111; req0_sub = 0; req0_valid = 1;
    req1_a = 32'h00000003; req1_b = 32'h00000004; req1_sub = 0; req1_valid = 1;
    @(negedge clk);
    chk("tie_r0", req0_ready, 1);
    chk("tie_r1", req1_ready, 0);
    push(32'h23456789, 0, 0);
    push(32'h00000007, 0, 1);
    @(posedge clk); #1; req0_valid = 0; req0_a = '1;
    n = 0;
    @(negedge clk);
    while (!req1_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("r1_timeout", 1, 0);
    @(posedge clk); #1; req1_valid = 0;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
